// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ===========================================================================
// fifo_rd_pkg : shared state encoding and default widths for fifo_burst_reader
// Rev 1.0
// ===========================================================================
package fifo_rd_pkg;

   localparam int FIFO_WIDTH_DEF = 32;
   localparam int LEN_W_DEF      = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_burst_reader_stream_buf2.sv
`default_nettype none
// ===========================================================================
// stream_buf2 : two-entry output buffer between the FIFO read port and stream
// Rev 1.0
// ===========================================================================
module stream_buf2 #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             capture_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [1:0]       occ_o,
   output logic [WIDTH-1:0] head_o
);

   logic [WIDTH-1:0] ent0_q;
   logic [WIDTH-1:0] ent1_q;
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       occ_q;
   logic [1:0]       occ_d;
   logic             w_pop;

   assign w_pop = pop_i & (occ_q != 2'd0);

   always_comb begin
      occ_d = occ_q;
      case ({capture_i, w_pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         ent0_q   <= '0;
         ent1_q   <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         if (capture_i) begin
            if (wr_ptr_q) begin
               ent1_q <= data_i;
            end else begin
               ent0_q <= data_i;
            end
            wr_ptr_q <= ~wr_ptr_q;
         end
         if (w_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         occ_q <= occ_d;
      end
   end

   assign occ_o  = occ_q;
   assign head_o = rd_ptr_q ? ent1_q : ent0_q;

endmodule
`default_nettype wire

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ===========================================================================
// fifo_burst_reader : pops N words from a registered-read FIFO onto a stream
// Rev 1.0
// ===========================================================================
module fifo_burst_reader
   import fifo_rd_pkg::*;
#(
   parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
   parameter int LEN_W      = LEN_W_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [LEN_W-1:0]      cmd_len_i,
   input  logic                  fifo_empty_i,
   input  logic [FIFO_WIDTH-1:0] fifo_data_i,
   output logic                  fifo_cs_o,
   output logic                  fifo_rd_en_o,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic [FIFO_WIDTH-1:0] m_data_o,
   output logic                  m_last_o,
   output logic                  busy_o,
   output logic                  done_o
);

   state_t           state_q;
   state_t           state_d;
   logic [LEN_W-1:0] issued_q;
   logic [LEN_W-1:0] issued_d;
   logic [LEN_W-1:0] delivered_q;
   logic [LEN_W-1:0] delivered_d;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] len_d;
   logic             inflight_q;

   logic [1:0]       w_occ;
   logic             w_pop_out;
   logic             w_rd_en;
   logic             w_last_idx;
   logic [2:0]       w_credit;

   assign w_pop_out  = m_valid_o & m_ready_i;
   assign w_last_idx = (delivered_q == (len_q - LEN_W'(1)));

   // Words buffered plus in flight after this cycle's output pop; never exceed two.
   assign w_credit = {1'b0, w_occ} + {2'b00, inflight_q} - {2'b00, w_pop_out};

   assign w_rd_en = (state_q == ST_READ) & ~fifo_empty_i &
                    (issued_q < len_q) & (w_credit < 3'd2);

   always_comb begin
      state_d     = state_q;
      issued_d    = issued_q;
      delivered_d = delivered_q;
      len_d       = len_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i) begin
               len_d       = cmd_len_i;
               issued_d    = '0;
               delivered_d = '0;
               state_d     = (cmd_len_i == '0) ? ST_DONE : ST_READ;
            end
         end
         ST_READ: begin
            if (w_rd_en) begin
               issued_d = issued_q + LEN_W'(1);
            end
            if (w_pop_out) begin
               delivered_d = delivered_q + LEN_W'(1);
               if (w_last_idx) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_IDLE;
         issued_q    <= '0;
         delivered_q <= '0;
         len_q       <= '0;
         inflight_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         issued_q    <= issued_d;
         delivered_q <= delivered_d;
         len_q       <= len_d;
         inflight_q  <= w_rd_en;
      end
   end

   stream_buf2 #(
      .WIDTH (FIFO_WIDTH)
   ) u_buf (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .capture_i (inflight_q),
      .data_i    (fifo_data_i),
      .pop_i     (w_pop_out),
      .occ_o     (w_occ),
      .head_o    (m_data_o)
   );

   assign m_valid_o    = (w_occ != 2'd0);
   assign m_last_o     = m_valid_o & w_last_idx;
   assign fifo_rd_en_o = w_rd_en;
   assign fifo_cs_o    = w_rd_en;
   assign cmd_ready_o  = (state_q == ST_IDLE);
   assign busy_o       = (state_q != ST_IDLE);
   assign done_o       = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ===========================================================================
// tb_fifo_burst_reader : directed bench with a FIFO model and stream scoreboard
// Rev 1.0
// ===========================================================================
module tb_fifo_burst_reader;

   localparam int W  = 32;
   localparam int LW = 8;

   logic          clk        = 1'b0;
   logic          rst_n      = 1'b0;
   logic          cmd_valid  = 1'b0;
   logic [LW-1:0] cmd_len    = '0;
   logic          fifo_empty = 1'b1;
   logic [W-1:0]  fifo_data  = '0;
   logic          m_ready    = 1'b0;
   logic          cmd_ready;
   logic          fifo_cs;
   logic          fifo_rd_en;
   logic          m_valid;
   logic [W-1:0]  m_data;
   logic          m_last;
   logic          busy;
   logic          done;

   fifo_burst_reader #(
      .FIFO_WIDTH (W),
      .LEN_W      (LW)
   ) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .cmd_valid_i  (cmd_valid),
      .cmd_ready_o  (cmd_ready),
      .cmd_len_i    (cmd_len),
      .fifo_empty_i (fifo_empty),
      .fifo_data_i  (fifo_data),
      .fifo_cs_o    (fifo_cs),
      .fifo_rd_en_o (fifo_rd_en),
      .m_valid_o    (m_valid),
      .m_ready_i    (m_ready),
      .m_data_o     (m_data),
      .m_last_o     (m_last),
      .busy_o       (busy),
      .done_o       (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] fifo_q[$];
   logic [W-1:0] wr_pend[$];
   logic [W-1:0] exp_q[$];
   logic [W-1:0] deliv_log[$];

   bit           mon_en = 1'b0;
   int           phase  = 0;     // 0 idle, 1 transferring, 2 completion cycle
   int           m_len  = 0;
   int           m_k    = 0;
   int           m_pops = 0;
   int           total_pops = 0;
   bit           hold_v = 1'b0;
   logic [W-1:0] hold_d = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Synchronous FIFO with one-cycle registered read; writes land at the next edge.
   always @(posedge clk) begin
      logic [W-1:0] w;
      if (fifo_rd_en && fifo_q.size() > 0) begin
         fifo_data <= fifo_q.pop_front();
      end
      while (wr_pend.size() > 0) begin
         w = wr_pend.pop_front();
         fifo_q.push_back(w);
         exp_q.push_back(w);
      end
      if (!rst_n) begin
         exp_q = fifo_q;
      end
      fifo_empty <= (fifo_q.size() == 0);
   end

   always @(negedge clk) begin
      bit hs;
      if (mon_en) begin
         hs = m_valid && m_ready && rst_n;
         chk("cs_eq_rd_en", fifo_cs, fifo_rd_en);
         chk("cmd_ready", cmd_ready, phase == 0);
         chk("busy", busy, phase != 0);
         chk("done", done, phase == 2);
         if (phase != 1) chk("m_valid_outside_burst", m_valid, 0);
         if (fifo_rd_en) chk("pop_while_empty", fifo_empty, 0);
         chk("m_last", m_last, m_valid && (m_k == m_len - 1));
         if (hold_v) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, hold_d);
         end
         hold_v = m_valid && !m_ready && rst_n;
         hold_d = m_data;
         if (hs) begin
            chk("exp_word_available", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               chk("m_data", m_data, exp_q[0]);
               void'(exp_q.pop_front());
            end
            deliv_log.push_back(m_data);
         end
         if (fifo_rd_en) begin
            m_pops++;
            total_pops++;
         end
         chk("pops_within_len", m_pops <= m_len, 1);
         chk("outstanding_le_2", (m_pops - (m_k + (hs ? 1 : 0))) <= 2, 1);

         if (!rst_n) begin
            phase  = 0;
            m_k    = 0;
            m_pops = 0;
         end else begin
            case (phase)
               0: if (cmd_valid) begin
                     m_len  = int'(cmd_len);
                     m_k    = 0;
                     m_pops = 0;
                     phase  = (cmd_len == 0) ? 2 : 1;
                  end
               1: if (hs) begin
                     if (m_k == m_len - 1) phase = 2;
                     m_k++;
                  end
               default: phase = 0;
            endcase
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [W-1:0] w);
      wr_pend.push_back(w);
   endtask

   task automatic start(input int len);
      cmd_len   = LW'(len);
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string name, input int bound);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         tick();
         if (done) seen = 1'b1;
      end
      chk({name, "_done_seen"}, seen, 1);
   endtask

   initial begin
      bit seen;
      int pops0;

      for (int i = 0; i < 4; i++) put(32'hA0 + i);
      repeat (3) tick();
      rst_n  = 1'b1;
      mon_en = 1'b1;

      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_cmd_ready", cmd_ready, 1);

      // Four-word burst, sink always ready.
      m_ready = 1'b1;
      start(4);
      chk("t1_c1_rd_en", fifo_rd_en, 1);
      chk("t1_c1_m_valid", m_valid, 0);
      tick();
      chk("t1_c2_m_valid", m_valid, 0);
      tick();
      chk("t1_c3_m_valid", m_valid, 1);
      chk("t1_c3_m_data", m_data, 32'hA0);
      for (int k = 1; k < 4; k++) begin
         tick();
         chk("t1_m_valid", m_valid, 1);
         chk("t1_m_data", m_data, 32'hA0 + k);
         chk("t1_m_last", m_last, k == 3);
      end
      tick();
      chk("t1_done", done, 1);
      chk("t1_done_m_valid", m_valid, 0);
      tick();
      chk("t1_cmd_ready", cmd_ready, 1);
      chk("t1_fifo_empty", fifo_q.size(), 0);

      // Zero-length command.
      pops0 = total_pops;
      start(0);
      chk("t2_done_c1", done, 1);
      chk("t2_cmd_ready_c1", cmd_ready, 0);
      tick();
      chk("t2_cmd_ready_c2", cmd_ready, 1);
      chk("t2_done_c2", done, 0);
      chk("t2_no_pops", total_pops - pops0, 0);

      // Starved FIFO: two words present, three more arrive later.
      deliv_log.delete();
      put(32'hB0);
      put(32'hB1);
      repeat (2) tick();
      start(5);
      repeat (7) tick();
      chk("t3_stall_rd_en", fifo_rd_en, 0);
      chk("t3_stall_m_valid", m_valid, 0);
      chk("t3_stall_count", m_k, 2);
      repeat (2) tick();
      for (int i = 2; i < 5; i++) put(32'hB0 + i);
      wait_done("t3", 40);
      tick();
      chk("t3_count", deliv_log.size(), 5);
      for (int i = 0; i < 5 && i < deliv_log.size(); i++) chk("t3_word", deliv_log[i], 32'hB0 + i);

      // Sink alternating ready/not-ready.
      deliv_log.delete();
      for (int i = 0; i < 6; i++) put(32'hC0 + i);
      repeat (2) tick();
      m_ready = 1'b1;
      start(6);
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         m_ready = ~m_ready;
         tick();
         if (done) seen = 1'b1;
      end
      chk("t4_done_seen", seen, 1);
      tick();
      m_ready = 1'b1;
      chk("t4_count", deliv_log.size(), 6);
      for (int i = 0; i < 6 && i < deliv_log.size(); i++) chk("t4_word", deliv_log[i], 32'hC0 + i);

      // Reset in the middle of an eight-word burst.
      deliv_log.delete();
      for (int i = 0; i < 8; i++) put(32'hD0 + i);
      repeat (2) tick();
      start(8);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (m_k == 2) seen = 1'b1;
      end
      chk("t5_two_delivered", seen, 1);
      m_ready = 1'b0;
      rst_n   = 1'b0;
      tick();
      rst_n   = 1'b1;
      chk("t5_m_valid", m_valid, 0);
      chk("t5_m_last", m_last, 0);
      chk("t5_done", done, 0);
      chk("t5_busy", busy, 0);
      chk("t5_rd_en", fifo_rd_en, 0);
      chk("t5_m_data", m_data, 0);
      chk("t5_cmd_ready", cmd_ready, 1);
      chk("t5_delivered", deliv_log.size(), 2);
      tick();
      chk("t5_no_done", done, 0);
      m_ready = 1'b1;
      start(1);
      wait_done("t5_len1", 10);
      tick();
      chk("t5_len1_count", deliv_log.size(), 3);
      if (deliv_log.size() == 3) chk("t5_len1_word", deliv_log[2], 32'hD4);

      // Command presented while busy must be ignored.
      deliv_log.delete();
      m_ready = 1'b0;
      start(3);
      repeat (3) tick();
      cmd_valid = 1'b1;
      cmd_len   = 8'd7;
      chk("t6_cmd_ready_busy", cmd_ready, 0);
      chk("t6_busy", busy, 1);
      repeat (2) tick();
      cmd_valid = 1'b0;
      m_ready   = 1'b1;
      wait_done("t6", 20);
      tick();
      chk("t6_count", deliv_log.size(), 3);
      for (int i = 0; i < 3 && i < deliv_log.size(); i++) chk("t6_word", deliv_log[i], 32'hD5 + i);
      chk("t6_fifo_empty", fifo_q.size(), 0);
      repeat (2) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
